serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial unsigned adder: the additive counterpart to the team's combinational subtracter.
//  Trades latency for area by computing a+b one bit per clock, LSB first, through a single carry flop.
//  Start/busy/done handshake; sits beside the ALU datapath for multi-cycle arithmetic operations.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2); also the number of RUN cycles
// PORTS
//  clk     in   1      single system clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE or DONE
//  a       in   WIDTH  operand A, captured on the accepted start edge
//  b       in   WIDTH  operand B, captured on the accepted start edge
//  sum     out  WIDTH  result, valid from the DONE cycle until the next accepted start
//  cout    out  1      carry-out (MSB carry), valid with sum
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle pulse in the DONE state
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; sum=0; cout=0; busy=0; done=0; carry flop=0; bit counter=0.
//   Takes effect immediately; an operation in progress is aborted with no done pulse.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> latch a,b into shift regs, carry=cin (0), counter=0, go RUN.
//   RUN : each edge: s_bit = a_sr[0]^b_sr[0]^carry; carry = majority(a_sr[0],b_sr[0],carry);
//         shift a_sr,b_sr right; shift s_bit into sum_sr MSB; counter++.
//         After the edge that processes bit WIDTH-1 -> DONE; sum<=sum_sr, cout<=final carry.
//         start is ignored in RUN (no queueing, no restart).
//   DONE: done=1 for exactly this cycle; next edge: start=1 -> RUN (back-to-back, new operands
//         latched), else IDLE.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges.
//  Throughput: one result per WIDTH+1 cycles when start is held high.
//  Arithmetic: modulo 2^WIDTH; cout = bit WIDTH of the full sum; no signed interpretation.
//  sum/cout do not change during RUN (internal sum_sr is used); they update only on entry to DONE.
//  a/b may change freely after the accepted start edge without affecting the result.
//  busy=1 exactly in RUN; busy and done are never high together.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined: adds input port sub (1 bit, captured with a/b on the accepted start edge).
//   sub=1 -> computes a-b: b latched inverted, initial carry=1; cout=1 means no borrow (a>=b).
//   sub=0 -> addition, identical to the undefined build.
//  SERIAL_ADDER_SUB_EN undefined: no sub port; addition only; initial carry always 0.
// TESTING (WIDTH=4)
//  1. reset, start with a=3,b=5 -> busy for 4 cycles, done pulse on the 5th edge, sum=8, cout=0.
//  2. a=15,b=1 -> sum=0, cout=1; a=15,b=15 -> sum=14, cout=1.
//  3. start pulsed again with a=1,b=1 during RUN of 3+5 -> ignored; result 8, single done pulse.
//  4. start held high, operands 2+2 then 7+9 -> done pulses 5 cycles apart, sum=4 then 0 with cout=1.
//  5. rst_n low mid-RUN -> sum=0, cout=0, busy=0, done=0 at once; no done pulse after release.
//  6. SERIAL_ADDER_SUB_EN: sub=1, 9-4 -> sum=5,cout=1; 4-9 -> sum=11,cout=0; sub=0, 9+4 -> 13.

Source files
------------

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. Computes a+b one bit per clock, LSB first,
//   through a single carry flop, with a start/busy/done handshake.
//   Latency: start accepted at edge k -> done high after edge k+WIDTH.
//
// Parameters
//   WIDTH  operand/result width (>=2); also the number of RUN cycles
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE or DONE
//   sub    in   (SERIAL_ADDER_SUB_EN only) 1 = compute a-b
//   a, b   in   operands, captured on the accepted start edge
//   sum    out  result, valid from DONE until the next accepted start
//   cout   out  carry-out (bit WIDTH of the sum); for a-b, 1 = no borrow
//   busy   out  high while in RUN
//   done   out  one-cycle pulse in DONE
//
// Build option
//   SERIAL_ADDER_SUB_EN  adds the sub port and subtraction (b inverted,
//                        initial carry 1). Undefined: addition only.
// ----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  // Holds the WIDTH-1 bits produced so far; the final bit is merged on the
  // last RUN edge, so a full WIDTH-bit register is never needed.
  logic [WIDTH-2:0] sum_sr_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             s_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_sr_d;
  logic [WIDTH-1:0] b_load_s;
  logic             cin_s;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // One full-adder step on the current LSBs plus the carry flop.
  always_comb begin
    s_bit_d  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_d  = maj3(a_sr_q[0], b_sr_q[0], carry_q);
    sum_sr_d = {s_bit_d, sum_sr_q};
  end

  // Operand B and initial carry as loaded on an accepted start.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    // a-b = a + ~b + 1: invert B and seed the carry with 1.
    b_load_s = sub ? ~b : b;
    cin_s    = sub;
`else
    b_load_s = b;
    cin_s    = 1'b0;
`endif
  end

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b_load_s;
            carry_q <= cin_s;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d[WIDTH-1:1];
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            // Outputs only move here, so sum/cout stay stable through RUN.
            sum_q   <= sum_sr_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=4). Stimulus pushes the
//   hand-computed {cout,sum} into a queue; a monitor pops and compares on
//   every done pulse. Latency, hold, back-to-back and reset abort are checked
//   inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_serial_adder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int done_cnt = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W:0] e);
    exp_q.push_back(e);
    n_push++;
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      check("busy_and_done", {31'd0, busy & done}, 32'd0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {27'd0, cout, sum}, {27'd0, e});
        end
      end
    end
  end

  // One operation; optionally pokes start during RUN, which must be ignored.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                    input logic [W:0] e, input logic poke, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_v;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: sub ignored in this build");
`endif
    push(e);
    @(negedge clk);
    n = 1;
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    check({nm, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    n = 2;
    check({nm, "_sum_hold"}, {27'd0, cout, sum}, {27'd0, last_cout, last_sum});
    if (poke) begin
      start = 1'b1;
      a = 4'd1;
      b = 4'd1;
      @(negedge clk);
      n = 3;
      start = 1'b0;
    end
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, 32'd5);
    last_sum = e[W-1:0];
    last_cout = e[W];
    @(negedge clk);
    check({nm, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int first;
    int second;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_outputs", {25'd0, sum, cout, busy, done}, 32'd0);
    rst_n = 1'b1;

    // Plain additions
    op(4'd3,  4'd5,  1'b0, {1'b0, 4'd8},  1'b0, "add_3_5");
    op(4'd15, 4'd1,  1'b0, {1'b1, 4'd0},  1'b0, "add_15_1");
    op(4'd15, 4'd15, 1'b0, {1'b1, 4'd14}, 1'b0, "add_15_15");
    op(4'd0,  4'd0,  1'b0, {1'b0, 4'd0},  1'b0, "add_0_0");
    op(4'd10, 4'd5,  1'b0, {1'b0, 4'd15}, 1'b0, "add_10_5");
    // start during RUN must be ignored
    op(4'd3,  4'd5,  1'b0, {1'b0, 4'd8},  1'b1, "ignore_start");
    repeat (8) @(negedge clk);

    // Back-to-back with start held: 2+2 then 7+9
    @(negedge clk);
    start = 1'b1;
    a = 4'd2;
    b = 4'd2;
    push({1'b0, 4'd4});
    first = 0;
    second = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 4'd7;
        b = 4'd9;
        push({1'b1, 4'd0});
      end
      if (n == 6) start = 1'b0;
      if (done) begin
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
    end
    check("b2b_first_done", first, 32'd5);
    check("b2b_second_done", second, 32'd10);
    last_sum = 4'd0;
    last_cout = 1'b1;

    // Reset mid-RUN after a nonzero result (10+5=15) is on the outputs
    op(4'd10, 4'd5, 1'b0, {1'b0, 4'd15}, 1'b0, "pre_reset");
    @(negedge clk);
    start = 1'b1;
    a = 4'd3;
    b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {25'd0, sum, cout, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    last_sum = 4'd0;
    last_cout = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    op(4'd9, 4'd4, 1'b1, {1'b1, 4'd5},  1'b0, "sub_9_4");
    op(4'd4, 4'd9, 1'b1, {1'b0, 4'd11}, 1'b0, "sub_4_9");
    op(4'd9, 4'd4, 1'b0, {1'b0, 4'd13}, 1'b0, "add_9_4");
`else
    op(4'd9, 4'd4, 1'b0, {1'b0, 4'd13}, 1'b0, "add_9_4");
`endif

    repeat (4) @(negedge clk);
    check("done_count", done_cnt, n_push);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
